write_dest_fsm: RTL and testbench

Destination-side engine of the DMA datapath. Pops beats that the read-source engine has pushed into the shared data FIFO and writes them to destination memory as AXI-MM write bursts. It waits for every write response, then pulses `wr_fsm_done`. The read side uses that pulse to retire the current descriptor.

---
 rtl/write_dest_fsm.sv | 226 ++++++++++++++++++++++
 tb/tb_write_dest_fsm.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/write_dest_fsm.sv
// write_dest_fsm: destination-side DMA engine. Pops beats from the show-ahead
// data FIFO and writes them to memory as AXI INCR bursts, then pulses
// wr_fsm_done once every write response has come back.
//
// state      | meaning
// IDLE       | waiting for a go descriptor
// ADDR_SETUP | presenting the AW for the current burst
// DATA_XFER  | streaming W beats from the FIFO
// WAIT_BRESP | all data sent, draining outstanding B responses
// DONE       | one-cycle completion pulse
module write_dest_fsm #(
    parameter int DATA_W      = 512,
    parameter int AXI_LEN_W   = 4,
    parameter int ADDR_W      = 64,
    parameter int LEN_W       = 32,
    parameter int PERF_CNTR_W = 32,
    parameter int ADDR_INCR   = (DATA_W / 8) * (2 ** AXI_LEN_W)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [ADDR_W-1:0]      desc_dest_addr,
    input  logic [LEN_W-1:0]       desc_length,
    input  logic                   desc_go,
    input  logic                   desc_mode,
    input  logic                   descriptor_fifo_not_empty,
    input  logic [DATA_W+1:0]      fifo_rd_data,
    input  logic                   fifo_empty,
    output logic                   fifo_rd_en,
    output logic                   dest_awvalid,
    input  logic                   dest_awready,
    output logic [ADDR_W-1:0]      dest_awaddr,
    output logic [7:0]             dest_awlen,
    output logic [2:0]             dest_awsize,
    output logic [1:0]             dest_awburst,
    output logic                   dest_wvalid,
    input  logic                   dest_wready,
    output logic [DATA_W-1:0]      dest_wdata,
    output logic [DATA_W/8-1:0]    dest_wstrb,
    output logic                   dest_wlast,
    input  logic                   dest_bvalid,
    output logic                   dest_bready,
    input  logic [1:0]             dest_bresp,
    output logic                   dest_arvalid,
    output logic                   dest_rready,
    output logic                   wr_fsm_done,
    output logic                   wr_dest_busy,
    output logic [4:0]             wr_dest_state,
    output logic                   wr_dest_err,
    output logic [PERF_CNTR_W-1:0] wr_dest_clk_cnt,
    output logic [PERF_CNTR_W-1:0] wr_dest_beat_cnt
);

    localparam int OUT_W = AXI_LEN_W + 1;
    localparam logic [2:0] AW_SIZE = 3'($clog2(DATA_W / 8));

    typedef enum logic [4:0] {
        S_IDLE       = 5'b00001,
        S_ADDR_SETUP = 5'b00010,
        S_DATA_XFER  = 5'b00100,
        S_WAIT_BRESP = 5'b01000,
        S_DONE       = 5'b10000
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_W-1:0]      awaddr_q, awaddr_d;
    logic [AXI_LEN_W-1:0]   awlen_q, awlen_d;
    logic [2:0]             awsize_q, awsize_d;
    logic [1:0]             awburst_q, awburst_d;
    logic                   awvalid_q, awvalid_d;
    logic [AXI_LEN_W-1:0]   last_len_q, last_len_d;
    logic [AXI_LEN_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [LEN_W-1:0]       num_bursts_q, num_bursts_d;
    logic [LEN_W-1:0]       burst_cnt_q, burst_cnt_d;
    logic [OUT_W-1:0]       outstanding_q, outstanding_d;
    logic                   err_q, err_d;
    logic [PERF_CNTR_W-1:0] clk_cnt_q, clk_cnt_d;
    logic [PERF_CNTR_W-1:0] beat_perf_q, beat_perf_d;

    logic             start, aw_hs, w_hs, b_hs, more_bursts, fifo_last;
    logic [LEN_W-1:0] len_m1, burst_inc;
    logic             unused_ok;

    // Packet-complete and mode are not needed on the write side.
    assign unused_ok = ^{desc_mode, fifo_rd_data[DATA_W+1]};

    assign fifo_last    = fifo_rd_data[DATA_W];
    assign start        = desc_go && descriptor_fifo_not_empty && (state_q == S_IDLE);
    assign dest_wdata   = fifo_rd_data[DATA_W-1:0];
    assign dest_wstrb   = '1;
    assign dest_arvalid = 1'b0;
    assign dest_rready  = 1'b0;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:       if (start) state_d = (desc_length == '0) ? S_DONE : S_ADDR_SETUP;
            S_ADDR_SETUP: if (aw_hs) state_d = S_DATA_XFER;
            S_DATA_XFER:  if (w_hs && dest_wlast) state_d = more_bursts ? S_ADDR_SETUP : S_WAIT_BRESP;
            S_WAIT_BRESP: if (outstanding_d == '0) state_d = S_DONE;
            S_DONE:       state_d = S_IDLE;
            default:      state_d = S_IDLE;
        endcase
    end

    // Channel outputs and handshake decode, all from current state.
    always_comb begin
        dest_wvalid   = (state_q == S_DATA_XFER) && !fifo_empty;
        dest_wlast    = (state_q == S_DATA_XFER) && (beat_cnt_q == awlen_q);
        dest_bready   = (state_q != S_IDLE);
        fifo_rd_en    = dest_wvalid && dest_wready;
        aw_hs         = awvalid_q && dest_awready;
        w_hs          = fifo_rd_en;
        b_hs          = dest_bvalid && dest_bready;
        wr_fsm_done   = (state_q == S_DONE);
        wr_dest_busy  = (state_q != S_IDLE);
        wr_dest_state = state_q;
    end

    assign dest_awvalid     = awvalid_q;
    assign dest_awaddr      = awaddr_q;
    assign dest_awlen       = 8'(awlen_q);
    assign dest_awsize      = awsize_q;
    assign dest_awburst     = awburst_q;
    assign wr_dest_err      = err_q;
    assign wr_dest_clk_cnt  = clk_cnt_q;
    assign wr_dest_beat_cnt = beat_perf_q;

    // Burst bookkeeping, AW fields, outstanding count, error and perf counters.
    always_comb begin
        len_m1        = desc_length - LEN_W'(1);
        burst_inc     = burst_cnt_q + LEN_W'(1);
        more_bursts   = burst_inc < num_bursts_q;
        awaddr_d      = awaddr_q;
        awlen_d       = awlen_q;
        awsize_d      = awsize_q;
        awburst_d     = awburst_q;
        last_len_d    = last_len_q;
        num_bursts_d  = num_bursts_q;
        burst_cnt_d   = burst_cnt_q;
        beat_cnt_d    = beat_cnt_q;
        outstanding_d = outstanding_q;
        clk_cnt_d     = clk_cnt_q;
        beat_perf_d   = beat_perf_q;

        if (start) begin
            num_bursts_d = (len_m1 >> AXI_LEN_W) + LEN_W'(1);
            last_len_d   = len_m1[AXI_LEN_W-1:0];
            awaddr_d     = desc_dest_addr;
            burst_cnt_d  = '0;
        end

        // awvalid rises one cycle into ADDR_SETUP; AW fields are loaded on
        // that first cycle so they are stable for the whole valid window.
        awvalid_d = (state_q == S_ADDR_SETUP) && !aw_hs;
        if ((state_q == S_ADDR_SETUP) && !awvalid_q) begin
            awlen_d   = more_bursts ? '1 : last_len_q;
            awsize_d  = AW_SIZE;
            awburst_d = 2'b01;
        end

        if (aw_hs)     beat_cnt_d = '0;
        else if (w_hs) beat_cnt_d = beat_cnt_q + AXI_LEN_W'(1);

        if (w_hs && dest_wlast) begin
            burst_cnt_d = burst_inc;
            if (more_bursts) awaddr_d = awaddr_q + ADDR_W'(ADDR_INCR);
        end

        unique case ({aw_hs, b_hs})
            2'b10:   outstanding_d = outstanding_q + OUT_W'(1);
            2'b01:   outstanding_d = outstanding_q - OUT_W'(1);
            default: outstanding_d = outstanding_q;
        endcase

        err_d = err_q || (b_hs && (dest_bresp != 2'b00)) || (w_hs && (fifo_last != dest_wlast));

        if (start && (desc_length != '0)) begin
            clk_cnt_d   = '0;
            beat_perf_d = '0;
        end else begin
            if (state_q != S_IDLE) clk_cnt_d = clk_cnt_q + PERF_CNTR_W'(1);
            if (w_hs)              beat_perf_d = beat_perf_q + PERF_CNTR_W'(1);
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            awaddr_q      <= '0;
            awlen_q       <= '0;
            awsize_q      <= '0;
            awburst_q     <= '0;
            awvalid_q     <= 1'b0;
            last_len_q    <= '0;
            num_bursts_q  <= '0;
            burst_cnt_q   <= '0;
            beat_cnt_q    <= '0;
            outstanding_q <= '0;
            err_q         <= 1'b0;
            clk_cnt_q     <= '0;
            beat_perf_q   <= '0;
        end else begin
            awaddr_q      <= awaddr_d;
            awlen_q       <= awlen_d;
            awsize_q      <= awsize_d;
            awburst_q     <= awburst_d;
            awvalid_q     <= awvalid_d;
            last_len_q    <= last_len_d;
            num_bursts_q  <= num_bursts_d;
            burst_cnt_q   <= burst_cnt_d;
            beat_cnt_q    <= beat_cnt_d;
            outstanding_q <= outstanding_d;
            err_q         <= err_d;
            clk_cnt_q     <= clk_cnt_d;
            beat_perf_q   <= beat_perf_d;
        end
    end

endmodule

// File: tb/tb_write_dest_fsm.sv
// tb_write_dest_fsm: directed + randomized descriptors against a queue-based
// reference of the expected AW/W/B traffic for write_dest_fsm.
module tb_write_dest_fsm;

    localparam int DW   = 32;
    localparam int LW   = 4;
    localparam int AW   = 32;
    localparam int LNW  = 16;
    localparam int PW   = 16;
    localparam int MAXB = 16;          // beats per full burst
    localparam int INCR = 4 * MAXB;    // bytes per full burst

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] desc_dest_addr = '0;
    logic [LNW-1:0] desc_length = '0;
    logic          desc_go = 1'b0, desc_mode = 1'b0, descriptor_fifo_not_empty = 1'b0;
    logic [DW+1:0] fifo_rd_data = '0;
    logic          fifo_empty = 1'b1;
    logic          fifo_rd_en;
    logic          awvalid, awready = 1'b0;
    logic [AW-1:0] awaddr;
    logic [7:0]    awlen;
    logic [2:0]    awsize;
    logic [1:0]    awburst;
    logic          wvalid, wready = 1'b0, wlast;
    logic [DW-1:0] wdata;
    logic [3:0]    wstrb;
    logic          bvalid = 1'b0, bready;
    logic [1:0]    bresp = 2'b00;
    logic          arvalid, rready;
    logic          done, busy, err;
    logic [4:0]    state;
    logic [PW-1:0] clk_cnt, beat_cnt;

    always #5 clk = ~clk;

    write_dest_fsm #(.DATA_W(DW), .AXI_LEN_W(LW), .ADDR_W(AW), .LEN_W(LNW), .PERF_CNTR_W(PW)) dut (
        .clk(clk), .reset(reset),
        .desc_dest_addr(desc_dest_addr), .desc_length(desc_length), .desc_go(desc_go),
        .desc_mode(desc_mode), .descriptor_fifo_not_empty(descriptor_fifo_not_empty),
        .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
        .dest_awvalid(awvalid), .dest_awready(awready), .dest_awaddr(awaddr),
        .dest_awlen(awlen), .dest_awsize(awsize), .dest_awburst(awburst),
        .dest_wvalid(wvalid), .dest_wready(wready), .dest_wdata(wdata),
        .dest_wstrb(wstrb), .dest_wlast(wlast),
        .dest_bvalid(bvalid), .dest_bready(bready), .dest_bresp(bresp),
        .dest_arvalid(arvalid), .dest_rready(rready),
        .wr_fsm_done(done), .wr_dest_busy(busy), .wr_dest_state(state),
        .wr_dest_err(err), .wr_dest_clk_cnt(clk_cnt), .wr_dest_beat_cnt(beat_cnt)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [DW+1:0] fifo_q[$];
    int            b_due[$];
    logic [1:0]    b_resp[$];
    bit            pop_pending = 0;
    bit            err_exp = 0;
    int            beat_cnt_exp = 0;
    int            clk_cnt_exp = 0;
    bit            prev_aw_pend = 0;
    logic [AW-1:0] prev_awaddr = '0;
    logic [7:0]    prev_awlen = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One cycle of stimulus, applied at the falling edge.
    task automatic drive(input bit go, input logic [AW-1:0] dest, input int len, input bit rnd);
        @(negedge clk);
        if (pop_pending && fifo_q.size() > 0) void'(fifo_q.pop_front());
        pop_pending = 0;
        cyc++;
        desc_go                   = go;
        descriptor_fifo_not_empty = go;
        desc_dest_addr            = dest;
        desc_length               = LNW'(len);
        fifo_empty   = (fifo_q.size() == 0) || (rnd && ($urandom_range(0, 3) == 0));
        fifo_rd_data = (fifo_q.size() > 0) ? fifo_q[0] : '0;
        wready       = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
        awready      = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        bvalid       = (b_due.size() > 0) && (b_due[0] <= cyc);
        bresp        = bvalid ? b_resp[0] : 2'b00;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        desc_go = 1'b0; descriptor_fifo_not_empty = 1'b0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; fifo_empty = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_state", state, 5'b00001);
        chk("rst_valids", {awvalid, wvalid, bready, fifo_rd_en, done, busy, err}, 0);
        chk("rst_aw_fields", {awaddr, awlen, awsize, awburst}, 0);
        chk("rst_counters", {clk_cnt, beat_cnt}, 0);
        @(negedge clk);
        reset = 1'b0;
        fifo_q.delete(); b_due.delete(); b_resp.delete();
        pop_pending = 0; err_exp = 0; beat_cnt_exp = 0; clk_cnt_exp = 0; prev_aw_pend = 0;
    endtask

    // Run one descriptor; expected traffic is derived from length arithmetic.
    task automatic run_desc(input logic [AW-1:0] dest, input int len, input bit rnd,
                            input int bdelay, input int slv_burst, input int bad_beat,
                            input int abort_at, output bit aborted);
        int nb, aw_idx, w_idx, b_idx, last_b_cyc, go_cyc, busy_cycles, bi, pos;
        bit done_seen, lastbit;
        logic [AW-1:0] exp_addr[$];
        int            exp_len[$];
        logic [DW-1:0] exp_data[$];
        logic [DW-1:0] d;
        aborted = 0; done_seen = 0;
        aw_idx = 0; w_idx = 0; b_idx = 0; last_b_cyc = -100; go_cyc = 0; busy_cycles = 0;
        nb = (len + MAXB - 1) / MAXB;
        for (int b = 0; b < nb; b++) begin
            exp_addr.push_back(dest + AW'(b * INCR));
            exp_len.push_back((b < nb - 1) ? MAXB - 1 : len - 1 - (nb - 1) * MAXB);
        end
        for (int j = 0; j < len; j++) begin
            d = $urandom;
            exp_data.push_back(d);
            lastbit = ((j % MAXB) == MAXB - 1) || (j == len - 1);
            if (j == bad_beat) lastbit = !lastbit;
            fifo_q.push_back({(j == len - 1), lastbit, d});
        end
        if ((slv_burst >= 0 && slv_burst < nb) || (bad_beat >= 0 && bad_beat < len)) err_exp = 1;

        for (int k = 0; k < 3000; k++) begin
            drive(1'b1, dest, len, rnd);
            if (k == 0) go_cyc = cyc;
            #1;
            chk("state_onehot", $onehot(state), 1);
            chk("busy", busy, state != 5'b00001);
            chk("bready", bready, busy);
            chk("rd_en_only_on_hs", fifo_rd_en, wvalid & wready);
            chk("wvalid_when_empty", wvalid & fifo_empty, 0);
            chk("ar_r_tied", {arvalid, rready}, 0);
            if (prev_aw_pend) chk("aw_hold", {awvalid, awaddr, awlen}, {1'b1, prev_awaddr, prev_awlen});
            prev_aw_pend = awvalid && !awready;
            prev_awaddr  = awaddr;
            prev_awlen   = awlen;
            if (state != 5'b00001) busy_cycles++;
            if (awvalid && awready) begin
                if (aw_idx < nb) begin
                    chk("awaddr", awaddr, exp_addr[aw_idx]);
                    chk("awlen", awlen, exp_len[aw_idx]);
                    chk("awsize_burst", {awsize, awburst}, {3'd2, 2'b01});
                end else chk("aw_extra", aw_idx, nb);
                aw_idx++;
            end
            if (wvalid && wready) begin
                if (w_idx < len) begin
                    bi  = w_idx / MAXB;
                    pos = w_idx % MAXB;
                    chk("w_after_aw", bi < aw_idx, 1);
                    chk("wdata", wdata, exp_data[w_idx]);
                    chk("wlast", wlast, pos == exp_len[bi]);
                    chk("wstrb", wstrb, 4'hf);
                    if (pos == exp_len[bi]) begin
                        b_due.push_back(cyc + 1 + bdelay);
                        b_resp.push_back((bi == slv_burst) ? 2'b10 : 2'b00);
                    end
                end else chk("w_extra", w_idx, len);
                w_idx++;
                pop_pending = 1;
            end
            if (bvalid && bready) begin
                void'(b_due.pop_front());
                void'(b_resp.pop_front());
                b_idx++;
                last_b_cyc = cyc;
            end
            if (done) begin
                done_seen = 1;
                chk("done_all_bresp", b_idx, nb);
                chk("done_all_beats", w_idx, len);
                chk("done_all_aw", aw_idx, nb);
                if (len > 0) chk("done_after_last_b", cyc - last_b_cyc, 1);
                else         chk("done_after_go_len0", cyc - go_cyc, 1);
                break;
            end
            if (abort_at > 0 && w_idx >= abort_at) begin
                aborted = 1;
                return;
            end
        end
        chk("done_timeout", done_seen, 1);

        drive(1'b0, dest, len, 1'b0);
        #1;
        chk("done_single_pulse", done, 0);
        chk("idle_after_done", {state, busy, awvalid, wvalid}, {5'b00001, 3'b000});
        chk("fifo_drained", fifo_q.size(), 0);
        if (len > 0) begin
            beat_cnt_exp = len;
            clk_cnt_exp  = busy_cycles;
        end else begin
            clk_cnt_exp = clk_cnt_exp + busy_cycles;
        end
        chk("perf_beat_cnt", beat_cnt, beat_cnt_exp);
        chk("perf_clk_cnt", clk_cnt, clk_cnt_exp);
        chk("err_flag", err, err_exp);
        drive(1'b0, dest, len, 1'b0);
        #1;
        chk("idle_hold", {state, done}, {5'b00001, 1'b0});
    endtask

    initial begin
        bit ab;
        do_reset();
        run_desc(32'h1000, 16, 0, 0, -1, -1, 0, ab);
        run_desc(32'h1000, 40, 0, 0, -1, -1, 0, ab);
        run_desc(32'h2000, 40, 1, 20, -1, -1, 0, ab);
        for (int i = 0; i < 3; i++)
            run_desc(AW'($urandom_range(0, 1023) * INCR), $urandom_range(1, 70), 1,
                     $urandom_range(0, 20), -1, -1, 0, ab);
        run_desc(32'h4000, 32, 0, 0, -1, -1, 0, ab);
        run_desc(32'h5000, 1, 0, 0, -1, -1, 0, ab);
        run_desc(32'h6000, 40, 1, 3, 1, -1, 0, ab);
        run_desc(32'h7000, 0, 0, 0, -1, -1, 0, ab);
        do_reset();
        run_desc(32'h8000, 40, 1, 5, -1, 5, 0, ab);
        do_reset();

        run_desc(32'h9000, 40, 0, 0, -1, -1, 20, ab);
        chk("abort_reached", ab, 1);
        @(negedge clk);
        reset = 1'b1;
        desc_go = 1'b0; descriptor_fifo_not_empty = 1'b0;
        @(posedge clk);
        #1;
        chk("midxfer_reset_idle", state, 5'b00001);
        chk("midxfer_reset_valids", {awvalid, wvalid, fifo_rd_en, done}, 0);
        do_reset();
        run_desc(32'hA000, 1, 0, 0, -1, -1, 0, ab);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
